// File: rtl/tiny_rv_pkg.sv
//----------------------------------------------------------------------------
// Module      : tiny_rv_pkg
// Description : Shared types for the tiny RV instruction/data memory arbiter:
//               arbiter FSM states, transaction owner encoding, counter width.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package tiny_rv_pkg;

    // Arbiter FSM states; one transaction outstanding at a time
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    // Which requester owns the current memory transaction
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

    // Width of the fetch starvation counter (limit range 1..15)
    localparam int unsigned STARVE_CNT_W = 4;

endpackage : tiny_rv_pkg

`default_nettype wire

// File: rtl/tiny_rv_mem_arb.sv
//----------------------------------------------------------------------------
// Module      : tiny_rv_mem_arb
// Description : Arbitrates a fetch port and a load/store port onto a single
//               memory request/response channel. Data accesses win by
//               default; the fetch response can be killed by a pipeline
//               flush. Optional fetch fairness is enabled by defining the
//               macro TINY_RV_ARB_FAIR_EN (STARVE_LIMIT consecutive data
//               grants while fetch waits, then fetch is served).
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tiny_rv_mem_arb
    import tiny_rv_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    // Fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    input  logic        if_kill,
    // Load/store port
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    // Shared response data
    output logic [31:0] rdata,
    // Memory request channel
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    // Memory accept/response channel
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [STARVE_CNT_W-1:0] c_starve_limit = STARVE_CNT_W'(STARVE_LIMIT);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    arb_owner_e         r_owner;
    logic               r_we;
    logic [3:0]         r_be;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_drop;

    logic               w_any_req;
    logic               w_force_if;
    logic               w_pick_if;

    assign w_any_req = if_req | dm_req;
    // Fetch wins only when data is not asking, or fairness overrides data
    assign w_pick_if = if_req & (~dm_req | w_force_if);

`ifdef TINY_RV_ARB_FAIR_EN
    logic [STARVE_CNT_W-1:0] r_starve_cnt;

    assign w_force_if = (r_starve_cnt >= c_starve_limit);

    // Count data wins taken while fetch was waiting; a fetch win clears it
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_starve_cnt <= '0;
        end else if ((r_state == ARB_IDLE) && w_any_req) begin
            if (w_pick_if) begin
                r_starve_cnt <= '0;
            end else if (if_req) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_force_if   = 1'b0;
    assign w_unused_cfg = ^c_starve_limit;
`endif

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the winner's request in IDLE; track fetch kills while it is in flight
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_drop  <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_any_req) begin
                        if (w_pick_if) begin
                            r_owner <= OWN_IF;
                            r_we    <= 1'b0;
                            r_be    <= 4'hF;
                            r_addr  <= if_addr;
                            r_wdata <= '0;
                        end else begin
                            r_owner <= OWN_DM;
                            r_we    <= dm_we;
                            r_be    <= dm_be;
                            r_addr  <= dm_addr;
                            r_wdata <= dm_wdata;
                        end
                    end
                end
                ARB_REQ, ARB_RESP: begin
                    if (if_kill && (r_owner == OWN_IF)) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_drop <= 1'b0;
                end
            endcase
        end
    end

    // Next state and all handshake/datapath outputs; everything idles at zero
    always_comb begin
        w_state_nxt = r_state;
        if_gnt      = 1'b0;
        dm_gnt      = 1'b0;
        if_rvalid   = 1'b0;
        dm_rvalid   = 1'b0;
        rdata       = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_be      = '0;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (r_state)
            ARB_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ARB_REQ;
                end
            end
            ARB_REQ: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_be    = r_be;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                if (mem_gnt) begin
                    if (r_owner == OWN_IF) begin
                        if_gnt = 1'b1;
                    end else begin
                        dm_gnt = 1'b1;
                    end
                    w_state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (mem_rvalid) begin
                    if (r_owner == OWN_DM) begin
                        dm_rvalid = 1'b1;
                        rdata     = mem_rdata;
                    end else if (!r_drop && !if_kill) begin
                        if_rvalid = 1'b1;
                        rdata     = mem_rdata;
                    end
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule : tiny_rv_mem_arb

`default_nettype wire

// File: doc/tiny_rv_mem_arb.md
TINY_RV_MEM_ARB -- requirements
Module: tiny_rv_mem_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning max consecutive data grants while fetch waits (range 1..15).
REQ-002 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port i_reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port if_req  input  1  fetch read request, held until if_gnt.
REQ-005 SHALL have port if_addr  input  32  fetch word address.
REQ-006 SHALL have port if_gnt  output  1  fetch request accepted by memory.
REQ-007 SHALL have port if_rvalid  output  1  fetch read data valid on rdata.
REQ-008 SHALL have port if_kill  input  1  pipeline flush; discard the pending fetch response.
REQ-009 SHALL have port dm_req  input  1  load/store request, held until dm_gnt.
REQ-010 SHALL have port dm_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port dm_be  input  4  store byte enables.
REQ-012 SHALL have port dm_addr  input  32  data address.
REQ-013 SHALL have port dm_wdata  input  32  store data.
REQ-014 SHALL have port dm_gnt  output  1  data request accepted by memory.
REQ-015 SHALL have port dm_rvalid  output  1  load data valid or store complete.
REQ-016 SHALL have port rdata  output  32  response data, shared by both requesters.
REQ-017 SHALL have port mem_req, mem_we, mem_be[4], mem_addr[32], mem_wdata[32]  output  memory request channel.
REQ-018 SHALL have port mem_gnt, mem_rvalid, mem_rdata[32]  input  memory accept / response channel.

Function
REQ-019 SHALL implement FSM IDLE -> REQ -> RESP -> IDLE, exactly one transaction outstanding.
REQ-020 IDLE: if any request pending, SHALL pick owner (data wins, unless fairness forces fetch), latch owner and request fields, enter REQ next cycle.
REQ-021 REQ: SHALL drive mem_* from latched fields, mem_req=1; on mem_gnt pulse owner's gnt one cycle (combinational with mem_gnt), enter RESP.
REQ-022 RESP: SHALL hold mem_req=0; on mem_rvalid pulse owner's rvalid one cycle with rdata=mem_rdata, return IDLE.
REQ-023 Latency: request seen in IDLE cycle N -> mem_req earliest N+1; back-to-back transactions SHALL have one IDLE cycle between them.
REQ-024 Fetch kill: if_kill in REQ or RESP with fetch owner SHALL set a drop flag; the transaction completes on the memory side but if_rvalid stays 0; flag clears in IDLE.
REQ-025 if_kill in same cycle as mem_rvalid SHALL suppress that if_rvalid; if_kill in IDLE SHALL have no effect.
REQ-026 rdata SHALL be 0 whenever no rvalid is asserted; if_gnt, dm_gnt, if_rvalid, dm_rvalid SHALL never be 1 together.
REQ-027 mem_rvalid in IDLE or REQ SHALL be ignored; mem_gnt outside REQ SHALL be ignored.

Reset
REQ-028 i_reset_n low SHALL force IDLE, clear owner, drop flag, starvation counter; all outputs 0 (mem_addr, mem_wdata, mem_be, rdata included), even mid-transaction.
REQ-029 After reset release the first arbitration SHALL occur on the first rising edge with i_reset_n high.

Configuration
REQ-030 With TINY_RV_ARB_FAIR_EN defined, a 4-bit counter SHALL count data grants while if_req is held, reset on fetch grant; at STARVE_LIMIT fetch SHALL win the next arbitration.
REQ-031 Without TINY_RV_ARB_FAIR_EN, data SHALL always win (strict priority), no counter logic present.

Structure
REQ-032 Package tiny_rv_pkg SHALL hold the FSM state enum (ARB_IDLE, ARB_REQ, ARB_RESP) and owner enum (OWN_IF, OWN_DM); no sub-module.

Verification
REQ-033 Fetch only: if_addr=0x100, mem_gnt after 2 cycles, mem_rvalid rdata=0xDEADBEEF -> one if_gnt, one if_rvalid, rdata=0xDEADBEEF.
REQ-034 Simultaneous if_req/dm_req (store 0x200, be=0xF, wdata=0x12345678) -> data served first with mem_we=1, fetch served in the following transaction.
REQ-035 if_kill pulsed in RESP of fetch -> mem handshake completes, if_rvalid never asserts, next dm_req served normally.
REQ-036 FAIR_EN, STARVE_LIMIT=4, dm_req and if_req held continuously -> grant order D,D,D,D,F repeating; without macro -> D only.
REQ-037 i_reset_n asserted in REQ with mem_req=1 -> mem_req and all outputs 0 immediately, FSM IDLE after release.
